kore_rfarb: RTL and testbench
=============================

KORE_RFARB -- requirements
Module: kore_rfarb

Interface
REQ-001 Parameter NREQ, default 4: number of requesting functional-unit FSMs (2..8).
REQ-002 Parameter AW, default 5: register-file address width.
REQ-003 Parameter DW, default 32: register data width.
REQ-004 Parameter LOCK_MAX, default 4: maximum consecutive transfers one locked owner may perform.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req  in  NREQ  per-requester access valid.
REQ-008 req_wr  in  NREQ  1 = write, 0 = read.
REQ-009 req_lock  in  NREQ  keep the port after this transfer.
REQ-010 req_addr  in  NREQ*AW  packed addresses; requester i at bits [i*AW +: AW].
REQ-011 req_wdata  in  NREQ*DW  packed write data; requester i at bits [i*DW +: DW].
REQ-012 gnt  out  NREQ  combinational one-hot (or zero) grant; transfer occurs on an edge where req[i]&gnt[i].
REQ-013 rdata_vld  out  NREQ  one-cycle pulse: read data for requester i on rdata.
REQ-014 rdata  out  DW  read data return.
REQ-015 rf_sel  out  AW  register-file address.
REQ-016 rf_rd  out  1  register-file read strobe.
REQ-017 rf_wt  out  1  register-file write enable.
REQ-018 rf_wdata  out  DW  register-file write data.
REQ-019 rf_rdata  in  DW  register-file read data, valid the cycle after rf_rd.
REQ-020 busy  out  1  high while in LOCKED or while a read is in flight.

Function
REQ-021 States: IDLE (no transfer last cycle), OPEN (unlocked transfer last cycle), LOCKED (port owned by requester own).
REQ-022 IDLE/OPEN: gnt goes to the first requester with req high, searching from rr_ptr upward with wrap from NREQ-1 to 0; gnt is 0 when req is 0.
REQ-023 LOCKED: gnt[own]=req[own]; all other gnt bits are 0.
REQ-024 On a transfer by requester i: rf_sel<=addr_i, rf_rd<=~wr_i, rf_wt<=wr_i, rf_wdata<=wdata_i (write) at that edge; strobes are 1-cycle pulses; rf_wdata holds its last value.
REQ-025 On a read transfer by requester i, rdata<=rf_rdata and rdata_vld[i]<=1 one edge after rf_rd; read-return latency is 2 edges from the transfer edge.
REQ-026 Throughput is one transfer per cycle; back-to-back reads from different requesters return in issue order.
REQ-027 Unlocked transfer by i: next state OPEN (LOCKED if req_lock[i]=1), rr_ptr<=(i+1) mod NREQ.
REQ-028 Transfer with req_lock[i]=1 from IDLE/OPEN: own<=i, lock_cnt<=1, next state LOCKED.
REQ-029 LOCKED transfer with req_lock=1 and lock_cnt<LOCK_MAX-1: stay LOCKED, lock_cnt increments.
REQ-030 LOCKED transfer with req_lock=0, or with lock_cnt=LOCK_MAX-1: state goes to OPEN and rr_ptr<=own+1 (forced release at LOCK_MAX transfers).
REQ-031 LOCKED with req[own]=0 for a cycle: state goes to IDLE at that edge with no transfer, and rr_ptr<=own+1.
REQ-032 No cycle has rf_rd and rf_wt both high, and at most one gnt bit is high.
REQ-033 req_lock is ignored on a transfer that releases the lock through LOCK_MAX.
REQ-034 No state is lost if req drops without a grant; requests are not queued.

Reset
REQ-035 While rst=1: state IDLE, rr_ptr=0, own=0, lock_cnt=0, rf_rd=0, rf_wt=0, rf_sel=0, rf_wdata=0, rdata=0, rdata_vld=0, busy=0, gnt=0.
REQ-036 Reset mid-operation discards any in-flight read: no rdata_vld pulse follows reset deassertion.
REQ-037 The first grant after reset goes to the lowest-index active requester.

Verification
REQ-038 req=4'b1111, no lock, all reads, held 8 cycles -> gnt order 0,1,2,3,0,1,2,3; each rdata_vld[i] pulses 2 edges after its transfer.
REQ-039 req1 write addr 5 data 0xDEADBEEF, then req2 read addr 5 -> rf_wt pulse with rf_sel=5, rf_wdata=0xDEADBEEF; rdata_vld[2] pulses with rdata = model RF value 0xDEADBEEF.
REQ-040 req0 lock held 1 for 6 transfers while req3 is active -> req0 receives 4 consecutive grants, then gnt[3]=1 on the next cycle; lock_cnt restarts at the next lock.
REQ-041 req2 locks, then drops req for 1 cycle while req0 is pending -> state IDLE at that edge; next grant goes to req3 if active, otherwise req0 (rr_ptr=3).
REQ-042 rst asserted the cycle after a read transfer -> rdata_vld stays 0; all outputs take their REQ-035 values; the next grant goes to the lowest active index.
REQ-043 Random req/req_wr/req_lock for 10k cycles, checked against a reference RF model -> gnt is always one-hot or zero; rf_rd and rf_wt are never both high; no requester waits more than NREQ*LOCK_MAX cycles for a grant.

Source files
------------

// File: rtl/kore_rfarb.sv
// kore_rfarb: arbitrates NREQ functional-unit FSMs onto a single register-file
// port. Round-robin between unlocked requesters; a requester may lock the port
// for up to LOCK_MAX consecutive transfers. Reads return two edges after the
// transfer edge on a shared rdata bus tagged by a one-hot rdata_vld.
module kore_rfarb #(
    parameter int NREQ     = 4,
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rdata_vld,
    output logic [DW-1:0]        rdata,
    output logic [AW-1:0]        rf_sel,
    output logic                 rf_rd,
    output logic                 rf_wt,
    output logic [DW-1:0]        rf_wdata,
    input  logic [DW-1:0]        rf_rdata,
    output logic                 busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OPEN   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_own;
    logic [CW-1:0]   r_lock_cnt;
    logic [AW-1:0]   r_sel;
    logic            r_rd;
    logic            r_wt;
    logic [DW-1:0]   r_wdata;
    logic [PW-1:0]   r_rd_idx;
    logic            r_pend;
    logic [PW-1:0]   r_pend_idx;
    logic [DW-1:0]   r_rdata;
    logic [NREQ-1:0] r_rdata_vld;

    logic [NREQ-1:0] w_gnt;
    logic [PW-1:0]   w_gidx;
    logic            w_xfer;
    logic            w_wr;
    logic            w_lock;
    logic            w_lock_last;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;

    // Successor index with wrap from NREQ-1 back to 0.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : PW'(int'(i) + 1);
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: locked owner keeps the port until it drops, unlocks or hits LOCK_MAX
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOCKED: begin
                if (!req[r_own])                w_state_nxt = S_IDLE;
                else if (!w_lock || w_lock_last) w_state_nxt = S_OPEN;
            end
            default: begin
                if (!w_xfer)                        w_state_nxt = S_IDLE;
                else if (w_lock && (LOCK_MAX > 1))  w_state_nxt = S_LOCKED;
                else                                w_state_nxt = S_OPEN;
            end
        endcase
    end

    // Grant output: owner only while locked, else first active requester from rr_ptr
    always_comb begin
        logic [PW-1:0] v_idx;
        logic          v_found;
        w_gnt   = '0;
        v_idx   = '0;
        v_found = 1'b0;
        if (!rst) begin
            if (r_state == S_LOCKED) begin
                w_gnt[r_own] = req[r_own];
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    v_idx = PW'((int'(r_rr_ptr) + k) % NREQ);
                    if (!v_found && req[v_idx]) begin
                        w_gnt[v_idx] = 1'b1;
                        v_found      = 1'b1;
                    end
                end
            end
        end
    end

    // Encode the one-hot grant to select the winner's request fields
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) w_gidx = PW'(i);
        end
    end

    assign w_xfer      = |w_gnt;
    assign w_wr        = req_wr[w_gidx];
    assign w_lock      = req_lock[w_gidx];
    assign w_addr      = req_addr[int'(w_gidx)*AW +: AW];
    assign w_wdata     = req_wdata[int'(w_gidx)*DW +: DW];
    assign w_lock_last = (r_lock_cnt == CW'(LOCK_MAX - 1));

    // Round-robin pointer, lock owner and count of transfers made under the lock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_own      <= '0;
            r_lock_cnt <= '0;
        end else if (r_state == S_LOCKED) begin
            if (req[r_own] && w_lock && !w_lock_last) begin
                r_lock_cnt <= r_lock_cnt + CW'(1);
            end else begin
                r_rr_ptr   <= next_idx(r_own);
                r_lock_cnt <= '0;
            end
        end else if (w_xfer) begin
            r_rr_ptr <= next_idx(w_gidx);
            if (w_lock && (LOCK_MAX > 1)) begin
                r_own      <= w_gidx;
                r_lock_cnt <= CW'(1);
            end
        end
    end

    // Register-file command: one-cycle strobes, address and write data held between transfers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd     <= 1'b0;
            r_wt     <= 1'b0;
            r_sel    <= '0;
            r_wdata  <= '0;
            r_rd_idx <= '0;
        end else begin
            r_rd <= w_xfer & ~w_wr;
            r_wt <= w_xfer &  w_wr;
            if (w_xfer) begin
                r_sel    <= w_addr;
                r_rd_idx <= w_gidx;
            end
            if (w_xfer && w_wr) r_wdata <= w_wdata;
        end
    end

    // Read return: wait one edge for the RF, then capture data and tag the requester
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend      <= 1'b0;
            r_pend_idx  <= '0;
            r_rdata     <= '0;
            r_rdata_vld <= '0;
        end else begin
            r_pend      <= r_rd;
            r_pend_idx  <= r_rd_idx;
            r_rdata_vld <= '0;
            if (r_pend) begin
                r_rdata                 <= rf_rdata;
                r_rdata_vld[r_pend_idx] <= 1'b1;
            end
        end
    end

    assign gnt       = w_gnt;
    assign rf_rd     = r_rd;
    assign rf_wt     = r_wt;
    assign rf_sel    = r_sel;
    assign rf_wdata  = r_wdata;
    assign rdata     = r_rdata;
    assign rdata_vld = r_rdata_vld;
    assign busy      = (r_state == S_LOCKED) | r_rd | r_pend;
endmodule

// File: tb/tb_kore_rfarb.sv
// Directed and random bench for kore_rfarb with a synchronous-read RF model.
`timescale 1ns/1ps
module tb_kore_rfarb;
    localparam int NREQ     = 4;
    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int LOCK_MAX = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                rf_clr = 1'b0;
    logic [NREQ-1:0]     req, req_wr, req_lock;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_wdata;
    logic [NREQ-1:0]     gnt, rdata_vld;
    logic [DW-1:0]       rdata, rf_wdata, rf_rdata;
    logic [AW-1:0]       rf_sel;
    logic                rf_rd, rf_wt, busy;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem [0:31];
    bit   [31:0]   mem_vld;
    logic [DW-1:0] ref_mem [0:31];

    typedef struct packed {
        logic [1:0]    idx;
        logic [DW-1:0] data;
    } rd_t;
    rd_t rd_q[$];

    kore_rfarb #(.NREQ(NREQ), .AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rdata_vld(rdata_vld),
        .rdata(rdata), .rf_sel(rf_sel), .rf_rd(rf_rd), .rf_wt(rf_wt),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file: synchronous write, synchronous read; unwritten words read A500_00aa
    always @(posedge clk) begin
        if (rf_clr) mem_vld <= '0;
        else if (rf_wt) begin
            mem[rf_sel]     <= rf_wdata;
            mem_vld[rf_sel] <= 1'b1;
        end
        if (rf_rd) rf_rdata <= mem_vld[rf_sel] ? mem[rf_sel] : (32'hA500_0000 | 32'(rf_sel));
    end

    task automatic drive_clear();
        req = '0; req_wr = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = 1'b1; req_wr[i] = wr; req_lock[i] = lk;
        req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; drive_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; drive_clear(); req = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (rf_rd !== 1'b0 || rf_wt !== 1'b0) begin failures++; $display("FAIL reset_strobes got rd=%b wt=%b exp 0 0", rf_rd, rf_wt); end
        checks++; if (rf_sel !== '0 || rf_wdata !== '0) begin failures++; $display("FAIL reset_rf got sel=%h wdata=%h exp 0 0", rf_sel, rf_wdata); end
        checks++; if (rdata !== '0 || rdata_vld !== '0) begin failures++; $display("FAIL reset_rdata got rdata=%h vld=%b exp 0 0", rdata, rdata_vld); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        next_cycle();
        rst = 1'b0; drive_clear(); req = 4'b0110;
        @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL first_grant got=%b exp=0010", gnt); end
        next_cycle(); drive_clear();
    endtask

    task automatic test_rr_reads();
        logic [3:0] exp_v;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            drive_clear();
            if (c < 8) for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, AW'(8 + i), '0);
            @(negedge clk);
            exp_v = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
            checks++; if (gnt !== exp_v) begin failures++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, exp_v); end
            if (c >= 1 && c <= 8) begin
                checks++;
                if (rf_rd !== 1'b1 || rf_wt !== 1'b0 || rf_sel !== AW'(8 + (c - 1) % 4)) begin
                    failures++; $display("FAIL rr_rfcmd c=%0d got rd=%b wt=%b sel=%0d exp rd=1 wt=0 sel=%0d", c, rf_rd, rf_wt, rf_sel, 8 + (c - 1) % 4);
                end
            end
            exp_v = (c >= 3 && c <= 10) ? 4'(1 << ((c - 3) % 4)) : 4'b0000;
            checks++; if (rdata_vld !== exp_v) begin failures++; $display("FAIL rr_vld c=%0d got=%b exp=%b", c, rdata_vld, exp_v); end
            if (c >= 3 && c <= 10) begin
                checks++;
                if (rdata !== (32'hA500_0008 + 32'((c - 3) % 4))) begin
                    failures++; $display("FAIL rr_rdata c=%0d got=%h exp=%h", c, rdata, 32'hA500_0008 + 32'((c - 3) % 4));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_write_read();
        do_reset();
        set_req(1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL wr_gnt got=%b exp=0010", gnt); end
        next_cycle();
        drive_clear(); set_req(2, 1'b0, 1'b0, 5'd5, '0);
        @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL rd_gnt got=%b exp=0100", gnt); end
        checks++;
        if (rf_wt !== 1'b1 || rf_rd !== 1'b0 || rf_sel !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL wr_cmd got wt=%b rd=%b sel=%0d wdata=%h exp wt=1 rd=0 sel=5 wdata=deadbeef", rf_wt, rf_rd, rf_sel, rf_wdata);
        end
        next_cycle();
        drive_clear();
        @(negedge clk);
        checks++;
        if (rf_rd !== 1'b1 || rf_wt !== 1'b0 || rf_sel !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL rd_cmd got rd=%b wt=%b sel=%0d wdata=%h exp rd=1 wt=0 sel=5 wdata=deadbeef", rf_rd, rf_wt, rf_sel, rf_wdata);
        end
        next_cycle();
        @(negedge clk);
        checks++; if (rdata_vld !== 4'b0000) begin failures++; $display("FAIL rd_early got=%b exp=0000", rdata_vld); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (rdata_vld !== 4'b0100 || rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL rd_return got vld=%b rdata=%h exp vld=0100 rdata=deadbeef", rdata_vld, rdata);
        end
        next_cycle();
        @(negedge clk);
        checks++; if (rdata_vld !== 4'b0000) begin failures++; $display("FAIL rd_pulse got=%b exp=0000", rdata_vld); end
        next_cycle();
    endtask

    task automatic test_lock();
        int seq [10];
        seq = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 3};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive_clear();
            set_req(0, 1'b0, 1'b1, 5'd1, '0);
            set_req(3, 1'b0, 1'b0, 5'd3, '0);
            @(negedge clk);
            checks++; if (gnt !== 4'(1 << seq[c])) begin failures++; $display("FAIL lock_gnt c=%0d got=%b exp=%b", c, gnt, 4'(1 << seq[c])); end
            if (c == 1) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL lock_busy got=%b exp=1", busy); end
            end
            next_cycle();
        end
        drive_clear();
        repeat (4) next_cycle();
    endtask

    task automatic test_lock_drop();
        logic [3:0] exp_v;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            set_req(2, 1'b0, 1'b1, 5'd2, '0);
            @(negedge clk);
            checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL drop_lockgnt v=%0d got=%b exp=0100", v, gnt); end
            next_cycle();
            set_req(0, 1'b0, 1'b0, 5'd0, '0);
            @(negedge clk);
            checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL drop_owned v=%0d got=%b exp=0100", v, gnt); end
            next_cycle();
            drive_clear(); set_req(0, 1'b0, 1'b0, 5'd0, '0);
            @(negedge clk);
            checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL drop_gap v=%0d got=%b exp=0000", v, gnt); end
            next_cycle();
            if (v == 0) set_req(3, 1'b0, 1'b0, 5'd3, '0);
            @(negedge clk);
            exp_v = (v == 0) ? 4'b1000 : 4'b0001;
            checks++; if (gnt !== exp_v) begin failures++; $display("FAIL drop_next v=%0d got=%b exp=%b", v, gnt, exp_v); end
            checks++; if (rf_rd !== 1'b0 || rf_wt !== 1'b0) begin failures++; $display("FAIL drop_noxfer v=%0d got rd=%b wt=%b exp 0 0", v, rf_rd, rf_wt); end
            next_cycle();
            drive_clear();
            repeat (3) next_cycle();
        end
    endtask

    task automatic test_reset_midread();
        do_reset();
        set_req(1, 1'b0, 1'b0, 5'd7, '0);
        @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL mid_gnt got=%b exp=0010", gnt); end
        next_cycle();
        rst = 1'b1; drive_clear();
        set_req(2, 1'b0, 1'b0, 5'd9, '0); set_req(3, 1'b0, 1'b0, 5'd10, '0);
        @(negedge clk);
        checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst_gnt got gnt=%b busy=%b exp 0000 0", gnt, busy); end
        checks++; if (rf_rd !== 1'b0 || rf_sel !== '0 || rf_wdata !== '0) begin failures++; $display("FAIL mid_rst_rf got rd=%b sel=%h wdata=%h exp 0 0 0", rf_rd, rf_sel, rf_wdata); end
        checks++; if (rdata !== '0 || rdata_vld !== '0) begin failures++; $display("FAIL mid_rst_rdata got rdata=%h vld=%b exp 0 0", rdata, rdata_vld); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL mid_first_gnt got=%b exp=0100", gnt); end
        checks++; if (rdata_vld !== 4'b0000) begin failures++; $display("FAIL mid_vld_c2 got=%b exp=0000", rdata_vld); end
        next_cycle();
        drive_clear();
        for (int c = 3; c < 5; c++) begin
            @(negedge clk);
            checks++; if (rdata_vld !== 4'b0000) begin failures++; $display("FAIL mid_vld_c%0d got=%b exp=0000", c, rdata_vld); end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (rdata_vld !== 4'b0100 || rdata !== 32'hA500_0009) begin
            failures++; $display("FAIL mid_after got vld=%b rdata=%h exp vld=0100 rdata=a5000009", rdata_vld, rdata);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] pend;
        int              wait_c [NREQ];
        logic            wait_bad;
        logic [AW-1:0]   a;
        rd_t             e;
        rf_clr = 1'b1;
        do_reset();
        rf_clr = 1'b0;
        for (int k = 0; k < 32; k++) ref_mem[k] = 32'hA500_0000 | 32'(k);
        pend = '0;
        for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
        rd_q.delete();
        for (int c = 0; c < 10008; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (c >= 10000) pend[i] = 1'b0;
                else if (!pend[i]) pend[i] = 1'($urandom_range(0, 1));
                req_wr[i]   = 1'($urandom_range(0, 1));
                req_lock[i] = 1'($urandom_range(0, 1));
                req_addr[i*AW +: AW]  = AW'($urandom_range(0, 31));
                req_wdata[i*DW +: DW] = $urandom;
            end
            req = pend;
            @(negedge clk);
            checks++;
            if (!$onehot0(gnt) || (gnt & ~req) !== '0) begin
                failures++; $display("FAIL rand_gnt c=%0d got gnt=%b req=%b exp onehot0 within req", c, gnt, req);
            end
            checks++;
            if (rf_rd === 1'b1 && rf_wt === 1'b1) begin failures++; $display("FAIL rand_strobes c=%0d got rd=1 wt=1 exp not both", c); end
            if (rdata_vld !== '0) begin
                checks++;
                if (rd_q.size() == 0) begin
                    failures++; $display("FAIL rand_vld_extra c=%0d got vld=%b exp 0000", c, rdata_vld);
                end else begin
                    e = rd_q.pop_front();
                    if (rdata_vld !== 4'(1 << e.idx) || rdata !== e.data) begin
                        failures++; $display("FAIL rand_rdata c=%0d got vld=%b rdata=%h exp vld=%b rdata=%h", c, rdata_vld, rdata, 4'(1 << e.idx), e.data);
                    end
                end
            end
            wait_bad = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && !gnt[i]) wait_c[i]++;
                else wait_c[i] = 0;
                if (wait_c[i] > NREQ * LOCK_MAX) wait_bad = 1'b1;
            end
            checks++;
            if (wait_bad) begin failures++; $display("FAIL rand_wait c=%0d got wait over %0d cycles exp bounded", c, NREQ * LOCK_MAX); end
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] && req[i]) begin
                    a = req_addr[i*AW +: AW];
                    if (req_wr[i]) ref_mem[a] = req_wdata[i*DW +: DW];
                    else rd_q.push_back('{idx: 2'(i), data: ref_mem[a]});
                    pend[i] = 1'b0;
                end
            end
            next_cycle();
        end
        checks++;
        if (rd_q.size() != 0) begin failures++; $display("FAIL rand_drain got %0d reads outstanding exp 0", rd_q.size()); end
        drive_clear();
    endtask

    initial begin
        drive_clear();
        test_reset();
        test_rr_reads();
        test_write_read();
        test_lock();
        test_lock_drop();
        test_reset_midread();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
